// File: rtl/sdrc_pkg.sv
// Shared definitions for the two-master SDRAM-controller Wishbone arbiter.
package sdrc_pkg;

   localparam int APP_AW_DEF = 26;
   localparam int DW_DEF     = 32;

   // Encoding chosen so the state vector doubles as the one-hot grant bus.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_tmo.sv
// Stall counter for the current bus owner; flags when the stall count
// has reached the configured limit.
module wb_arb_tmo #(
   parameter int TMO_CYC = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic stall_i,
   input  logic clr_i,
   output logic tmo_o
);

   logic [7:0] cnt_q, cnt_d;

   // Clear wins over counting so a grant change always starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = 8'd0;
      else if (stall_i)
         cnt_d = cnt_q + 8'd1;
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

   assign tmo_o = (cnt_q == 8'(TMO_CYC));

endmodule

// File: rtl/wb_sdrc_arbiter.sv
// Round-robin arbiter giving two Wishbone masters access to one SDRAM
// controller slave port, with an ack timeout that recovers a hung owner.
//
// state   | meaning
// --------+--------------------------------------------
// ST_IDLE | no owner, slave port driven to zero
// ST_GNT0 | master 0 owns the slave port until cyc drops
// ST_GNT1 | master 1 owns the slave port until cyc drops
module wb_sdrc_arbiter
   import sdrc_pkg::*;
#(
   parameter int APP_AW  = APP_AW_DEF,
   parameter int dw      = DW_DEF,
   parameter int TMO_CYC = 255
) (
   input  logic              wb_clk,
   input  logic              wb_resetn,
   input  logic              m0_wb_cyc,
   input  logic              m0_wb_stb,
   input  logic              m0_wb_we,
   input  logic [APP_AW-1:0] m0_wb_addr,
   input  logic [dw/8-1:0]   m0_wb_sel,
   input  logic [dw-1:0]     m0_wb_dati,
   input  logic [2:0]        m0_wb_cti,
   output logic [dw-1:0]     m0_wb_dato,
   output logic              m0_wb_ack,
   output logic              m0_wb_err,
   input  logic              m1_wb_cyc,
   input  logic              m1_wb_stb,
   input  logic              m1_wb_we,
   input  logic [APP_AW-1:0] m1_wb_addr,
   input  logic [dw/8-1:0]   m1_wb_sel,
   input  logic [dw-1:0]     m1_wb_dati,
   input  logic [2:0]        m1_wb_cti,
   output logic [dw-1:0]     m1_wb_dato,
   output logic              m1_wb_ack,
   output logic              m1_wb_err,
   output logic              s_wb_cyc,
   output logic              s_wb_stb,
   output logic              s_wb_we,
   output logic [APP_AW-1:0] s_wb_addr,
   output logic [dw/8-1:0]   s_wb_sel,
   output logic [dw-1:0]     s_wb_dati,
   output logic [2:0]        s_wb_cti,
   input  logic [dw-1:0]     s_wb_dato,
   input  logic              s_wb_ack,
   output logic [1:0]        grant
);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;   // 1: master 1 was served last
   logic              own_cyc, own_stb, own_we;
   logic [APP_AW-1:0] own_addr;
   logic [dw/8-1:0]   own_sel;
   logic [dw-1:0]     own_dati;
   logic [2:0]        own_cti;
   logic              stall, tmo_hit, tmo;

   // Select the current owner's request; everything zero with no owner.
   always_comb begin
      own_cyc  = 1'b0;
      own_stb  = 1'b0;
      own_we   = 1'b0;
      own_addr = '0;
      own_sel  = '0;
      own_dati = '0;
      own_cti  = CTI_CLASSIC;
      case (state_q)
         ST_GNT0: begin
            own_cyc  = m0_wb_cyc;
            own_stb  = m0_wb_stb;
            own_we   = m0_wb_we;
            own_addr = m0_wb_addr;
            own_sel  = m0_wb_sel;
            own_dati = m0_wb_dati;
            own_cti  = m0_wb_cti;
         end
         ST_GNT1: begin
            own_cyc  = m1_wb_cyc;
            own_stb  = m1_wb_stb;
            own_we   = m1_wb_we;
            own_addr = m1_wb_addr;
            own_sel  = m1_wb_sel;
            own_dati = m1_wb_dati;
            own_cti  = m1_wb_cti;
         end
         default: ;
      endcase
   end

   // A coincident slave ack always beats the timeout.
   assign stall = own_cyc & own_stb & ~s_wb_ack;
   assign tmo   = tmo_hit & stall;

   // Next owner: held for the whole cyc, re-arbitrated only on release or timeout.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      if (tmo) begin
         state_d = ST_IDLE;
         last_d  = (state_q == ST_GNT1);
      end else if ((state_q == ST_IDLE) || !own_cyc) begin
         if (m0_wb_cyc && (!m1_wb_cyc || last_q)) begin
            state_d = ST_GNT0;
            last_d  = 1'b0;
         end else if (m1_wb_cyc) begin
            state_d = ST_GNT1;
            last_d  = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // State and round-robin pointer; m0 gets first pick out of reset.
   always_ff @(posedge wb_clk or negedge wb_resetn) begin
      if (!wb_resetn) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   wb_arb_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
      .clk_i   (wb_clk),
      .rst_n_i (wb_resetn),
      .stall_i (stall),
      .clr_i   (~stall | (state_d != state_q)),
      .tmo_o   (tmo_hit)
   );

   assign grant      = state_q;
   assign s_wb_cyc   = own_cyc & ~tmo;
   assign s_wb_stb   = own_stb & ~tmo;
   assign s_wb_we    = own_we;
   assign s_wb_addr  = own_addr;
   assign s_wb_sel   = own_sel;
   assign s_wb_dati  = own_dati;
   assign s_wb_cti   = own_cti;
   assign m0_wb_ack  = s_wb_ack & (state_q == ST_GNT0);
   assign m1_wb_ack  = s_wb_ack & (state_q == ST_GNT1);
   assign m0_wb_err  = tmo & (state_q == ST_GNT0);
   assign m1_wb_err  = tmo & (state_q == ST_GNT1);
   assign m0_wb_dato = s_wb_dato;
   assign m1_wb_dato = s_wb_dato;

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Directed bench for wb_sdrc_arbiter: a cycle-by-cycle vector table for
// basic arbitration plus hand-written burst, timeout and reset sequences.
module tb_wb_sdrc_arbiter;
   import sdrc_pkg::*;

   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          wb_clk = 1'b0;
   logic          wb_resetn;
   logic          m0_wb_cyc, m0_wb_stb, m0_wb_we;
   logic [AW-1:0] m0_wb_addr;
   logic [3:0]    m0_wb_sel;
   logic [DW-1:0] m0_wb_dati;
   logic [2:0]    m0_wb_cti;
   logic [DW-1:0] m0_wb_dato;
   logic          m0_wb_ack, m0_wb_err;
   logic          m1_wb_cyc, m1_wb_stb, m1_wb_we;
   logic [AW-1:0] m1_wb_addr;
   logic [3:0]    m1_wb_sel;
   logic [DW-1:0] m1_wb_dati;
   logic [2:0]    m1_wb_cti;
   logic [DW-1:0] m1_wb_dato;
   logic          m1_wb_ack, m1_wb_err;
   logic          s_wb_cyc, s_wb_stb, s_wb_we;
   logic [AW-1:0] s_wb_addr;
   logic [3:0]    s_wb_sel;
   logic [DW-1:0] s_wb_dati;
   logic [2:0]    s_wb_cti;
   logic [DW-1:0] s_wb_dato;
   logic          s_wb_ack;
   logic [1:0]    grant;

   int n_tests = 0;
   int n_fail  = 0;

   wb_sdrc_arbiter #(.APP_AW(AW), .dw(DW), .TMO_CYC(TMO)) dut (
      .wb_clk(wb_clk), .wb_resetn(wb_resetn),
      .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
      .m0_wb_addr(m0_wb_addr), .m0_wb_sel(m0_wb_sel), .m0_wb_dati(m0_wb_dati),
      .m0_wb_cti(m0_wb_cti), .m0_wb_dato(m0_wb_dato), .m0_wb_ack(m0_wb_ack),
      .m0_wb_err(m0_wb_err),
      .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
      .m1_wb_addr(m1_wb_addr), .m1_wb_sel(m1_wb_sel), .m1_wb_dati(m1_wb_dati),
      .m1_wb_cti(m1_wb_cti), .m1_wb_dato(m1_wb_dato), .m1_wb_ack(m1_wb_ack),
      .m1_wb_err(m1_wb_err),
      .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
      .s_wb_addr(s_wb_addr), .s_wb_sel(s_wb_sel), .s_wb_dati(s_wb_dati),
      .s_wb_cti(s_wb_cti), .s_wb_dato(s_wb_dato), .s_wb_ack(s_wb_ack),
      .grant(grant)
   );

   always #5 wb_clk = ~wb_clk;

   typedef struct {
      logic       c0, s0, c1, s1, ack;
      logic [1:0] grant;
      logic       a0, a1, scyc;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mkv(input logic [4:0] in, input logic [1:0] g, input logic [2:0] o);
      vec_t v;
      {v.c0, v.s0, v.c1, v.s1, v.ack} = in;
      v.grant = g;
      {v.a0, v.a1, v.scyc} = o;
      return v;
   endfunction

   // Expected slave-side request bus for a given owner, built from the master drives.
   function automatic logic [127:0] exp_bus(input logic [1:0] g);
      case (g)
         2'b01:   return 128'({m0_wb_addr, m0_wb_we, m0_wb_sel, m0_wb_dati, m0_wb_cti});
         2'b10:   return 128'({m1_wb_addr, m1_wb_we, m1_wb_sel, m1_wb_dati, m1_wb_cti});
         default: return 128'd0;
      endcase
   endfunction

   function automatic logic [127:0] act_bus();
      return 128'({s_wb_addr, s_wb_we, s_wb_sel, s_wb_dati, s_wb_cti});
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1, input logic ack);
      m0_wb_cyc = c0; m0_wb_stb = s0;
      m1_wb_cyc = c1; m1_wb_stb = s1;
      s_wb_ack  = ack;
   endtask

   task automatic do_reset();
      wb_resetn = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      m0_wb_cti = CTI_CLASSIC;
      m1_wb_cti = CTI_CLASSIC;
      repeat (2) next_cycle();
      chk("reset_grant", 128'(grant), 128'd0);
      chk("reset_scyc", 128'({s_wb_cyc, s_wb_stb}), 128'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      m0_wb_addr = 26'h0000100; m0_wb_we = 1'b1; m0_wb_sel = 4'hF; m0_wb_dati = 32'hA0A0_0000;
      m1_wb_addr = 26'h0000200; m1_wb_we = 1'b0; m1_wb_sel = 4'h3; m1_wb_dati = 32'h5151_0001;
      m0_wb_cti  = CTI_CLASSIC; m1_wb_cti = CTI_CLASSIC;
      s_wb_dato  = 32'hDEAD_BEEF;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      //              c0 s0 c1 s1 ack   grant   a0 a1 scyc
      vecs[0]  = mkv(5'b00000, 2'b00, 3'b000);
      vecs[1]  = mkv(5'b00001, 2'b00, 3'b000);  // ack while idle ignored
      vecs[2]  = mkv(5'b11000, 2'b00, 3'b000);  // m0 request seen
      vecs[3]  = mkv(5'b11000, 2'b01, 3'b001);  // granted one edge later
      vecs[4]  = mkv(5'b11001, 2'b01, 3'b101);  // slave ack routed to m0
      vecs[5]  = mkv(5'b00110, 2'b01, 3'b000);  // m0 released, m1 asks
      vecs[6]  = mkv(5'b11110, 2'b10, 3'b001);  // m1 owns, m0 waits
      vecs[7]  = mkv(5'b11111, 2'b10, 3'b011);
      vecs[8]  = mkv(5'b11000, 2'b10, 3'b000);  // m1 released
      vecs[9]  = mkv(5'b11001, 2'b01, 3'b101);  // m0 back-to-back, no idle
      vecs[10] = mkv(5'b00000, 2'b01, 3'b000);
      vecs[11] = mkv(5'b00001, 2'b00, 3'b000);  // idle, ack ignored
      vecs[12] = mkv(5'b11110, 2'b00, 3'b000);  // both ask, m0 served last
      vecs[13] = mkv(5'b11110, 2'b10, 3'b001);  // so m1 wins
      vecs[14] = mkv(5'b00000, 2'b10, 3'b000);
      vecs[15] = mkv(5'b00000, 2'b00, 3'b000);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1, vecs[i].ack);
         #3;
         chk($sformatf("v%0d_grant", i), 128'(grant), 128'(vecs[i].grant));
         chk($sformatf("v%0d_ack", i), 128'({m0_wb_ack, m1_wb_ack}), 128'({vecs[i].a0, vecs[i].a1}));
         chk($sformatf("v%0d_scyc_stb", i), 128'({s_wb_cyc, s_wb_stb}), 128'({vecs[i].scyc, vecs[i].scyc}));
         chk($sformatf("v%0d_bus", i), act_bus(), exp_bus(vecs[i].grant));
         chk($sformatf("v%0d_err", i), 128'({m0_wb_err, m1_wb_err}), 128'd0);
         next_cycle();
      end
      chk("dato_m0", 128'(m0_wb_dato), 128'(32'hDEAD_BEEF));
      chk("dato_m1", 128'(m1_wb_dato), 128'(32'hDEAD_BEEF));

      // Simultaneous requests after reset: m0 first, then m1 with no idle gap.
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #3 chk("sim_req_grant0", 128'(grant), 128'd0);
      next_cycle();
      #3 chk("sim_req_m0_first", 128'(grant), 128'(2'b01));
      chk("sim_req_bus", act_bus(), exp_bus(2'b01));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      next_cycle();
      #3 chk("sim_req_m1_next", 128'(grant), 128'(2'b10));

      // m1 four-beat incrementing burst while m0 waits.
      do_reset();
      m1_wb_cti = CTI_INCR;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int b = 0; b < 4; b++) begin
         m1_wb_cti = (b == 3) ? CTI_EOB : CTI_INCR;
         #3;
         chk($sformatf("burst%0d_grant", b), 128'(grant), 128'(2'b10));
         chk($sformatf("burst%0d_ack", b), 128'({m0_wb_ack, m1_wb_ack}), 128'(2'b01));
         chk($sformatf("burst%0d_cti", b), 128'(s_wb_cti), 128'((b == 3) ? CTI_EOB : CTI_INCR));
         next_cycle();
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      m1_wb_cti = CTI_CLASSIC;
      #3 chk("burst_release_hold", 128'(grant), 128'(2'b10));
      next_cycle();
      #3 chk("burst_then_m0", 128'(grant), 128'(2'b01));

      // Slave never acks m0: error in the cycle the stall count reaches TMO.
      do_reset();
      m0_wb_we = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= TMO; i++) begin
         #3;
         chk($sformatf("tmo_stall%0d", i), 128'({m0_wb_err, s_wb_cyc}), 128'(2'b01));
         next_cycle();
      end
      #3;
      chk("tmo_err", 128'({m0_wb_err, m1_wb_err}), 128'(2'b10));
      chk("tmo_force_low", 128'({s_wb_cyc, s_wb_stb}), 128'd0);
      chk("tmo_grant_still", 128'(grant), 128'(2'b01));
      next_cycle();
      #3;
      chk("tmo_idle", 128'(grant), 128'd0);
      chk("tmo_err_pulse", 128'(m0_wb_err), 128'd0);
      next_cycle();
      #3 chk("tmo_m1_next", 128'(grant), 128'(2'b10));
      m0_wb_we = 1'b1;

      // Slave ack coincides with the timeout cycle: ack wins.
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      repeat (TMO) next_cycle();
      s_wb_ack = 1'b1;
      #3;
      chk("tmo_ack_wins", 128'({m0_wb_ack, m0_wb_err}), 128'(2'b10));
      chk("tmo_ack_scyc", 128'(s_wb_cyc), 128'd1);
      next_cycle();
      s_wb_ack = 1'b0;
      #3 chk("tmo_ack_cleared", 128'({grant, m0_wb_err}), 128'({2'b01, 1'b0}));

      // Reset asserted mid-burst on m1, then simultaneous requests.
      do_reset();
      m1_wb_cti = CTI_INCR;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      #3 chk("rst_burst_ack", 128'(m1_wb_ack), 128'd1);
      #1 wb_resetn = 1'b0;
      #1;
      chk("rst_async_grant", 128'(grant), 128'd0);
      chk("rst_async_slave", 128'({s_wb_cyc, s_wb_stb, s_wb_we, s_wb_addr, s_wb_cti}), 128'd0);
      chk("rst_async_ackerr", 128'({m0_wb_ack, m1_wb_ack, m0_wb_err, m1_wb_err}), 128'd0);
      next_cycle();
      m1_wb_cti = CTI_CLASSIC;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wb_resetn = 1'b1;
      #3 chk("rst_release_idle", 128'(grant), 128'd0);
      next_cycle();
      #3 chk("rst_release_m0", 128'(grant), 128'(2'b01));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_sdrc_arbiter.md
WB_SDRC_ARBITER -- requirements
Module: wb_sdrc_arbiter

Interface
REQ-001 Parameter APP_AW, default 26, Wishbone address width.
REQ-002 Parameter dw, default 32, Wishbone data width; sel width = dw/8.
REQ-003 Parameter TMO_CYC, default 255, ack-timeout limit in wb_clk cycles (1..255).
REQ-004 wb_clk  in  1  single clock, all logic rising-edge.
REQ-005 wb_resetn  in  1  asynchronous active-low reset.
REQ-006 mN_wb_cyc / mN_wb_stb / mN_wb_we  in  1 each  master N (N=0,1) cycle, strobe, write-enable.
REQ-007 mN_wb_addr  in  APP_AW  master N address.
REQ-008 mN_wb_sel  in  dw/8  master N byte select.
REQ-009 mN_wb_dati  in  dw  master N write data.
REQ-010 mN_wb_cti  in  3  master N cycle-type identifier.
REQ-011 mN_wb_dato  out  dw  read data to master N.
REQ-012 mN_wb_ack / mN_wb_err  out  1 each  acknowledge / timeout error to master N.
REQ-013 s_wb_cyc, s_wb_stb, s_wb_we  out  1 each  to SDRAM controller slave port.
REQ-014 s_wb_addr APP_AW, s_wb_sel dw/8, s_wb_dati dw, s_wb_cti 3  out  muxed request to slave.
REQ-015 s_wb_dato  in  dw  slave read data; s_wb_ack  in  1  slave acknowledge.
REQ-016 grant  out  2  one-hot current owner (00 = none), for debug/monitor.

Function
REQ-017 FSM states IDLE, GNT0, GNT1; state register only, grant = state decode.
REQ-018 Request N = mN_wb_cyc; arbitration evaluated when state is IDLE or current owner's cyc is low.
REQ-019 Round-robin: single requester wins; both requesting -> master not served last wins; after reset, m0 has priority.
REQ-020 Arbitration latency: request seen at edge k -> grant and s_wb_cyc valid after edge k+1.
REQ-021 Owner releases by dropping cyc; next owner granted on the following edge, no idle cycle if the other master is requesting; IDLE if none.
REQ-022 Grant is held for the owner's entire cyc, including cti=010 incrementing bursts; no preemption.
REQ-023 s_wb_cyc/stb/we/addr/sel/dati/cti = owner's signals combinationally; all zero in IDLE.
REQ-024 mN_wb_ack = s_wb_ack AND owner==N; non-owner ack, err always 0.
REQ-025 mN_wb_dato = s_wb_dato for both masters (data qualified by ack).
REQ-026 Timeout counter (8 bits) increments each cycle owner stb=1 and s_wb_ack=0; clears on ack, stb low, or grant change.
REQ-027 Counter reaching TMO_CYC: one-cycle mN_wb_err to owner, s_wb_cyc/stb forced low that cycle, FSM returns to IDLE, last-served pointer set to that owner.
REQ-028 s_wb_ack arriving in the same cycle as timeout -> ack wins, no err, counter clears.
REQ-029 s_wb_ack while IDLE is ignored (no master ack).

Reset
REQ-030 wb_resetn low: state=IDLE, grant=00, last-served=m1 (so m0 wins first), timeout counter=0, all s_wb_* and mN_wb_ack/err=0, asynchronously.
REQ-031 Reset mid-transfer aborts immediately; no ack/err emitted; release is synchronous to wb_clk.

Structure
REQ-032 Shared package sdrc_pkg holds state enum (IDLE/GNT0/GNT1), cti codes (CLASSIC=000, INCR=010, EOB=111), APP_AW/dw defaults.
REQ-033 One sub-module wb_arb_tmo (timeout counter + compare) natural; mux and FSM in top.

Verification
REQ-034 m0 single write, m1 idle -> grant=01 one edge after cyc, s_wb_addr=m0 addr, m0_wb_ack on slave ack, m1_wb_ack=0.
REQ-035 m0,m1 cyc asserted same edge after reset -> m0 granted first; m0 drops cyc -> m1 granted next edge, no IDLE cycle.
REQ-036 m1 4-beat INCR burst (cti 010,010,010,111) while m0 requests -> grant stays 10 for all 4 acks, then switches to m0.
REQ-037 TMO_CYC=8, slave never acks m0 read -> m0_wb_err pulse after 8 stalled cycles, grant=00 next cycle, m1 then granted if requesting.
REQ-038 Ack and timeout coincident (ack on cycle 8) -> m0_wb_ack=1, m0_wb_err=0.
REQ-039 wb_resetn asserted during m1 burst -> all outputs 0 asynchronously; after release, simultaneous requests grant m0.
